csa_accumulator: RTL and testbench

CSA_ACCUMULATOR -- requirements
Module: csa_accumulator

---
 rtl/csa_accumulator.sv | 93 +++++++++
 tb/tb_csa_accumulator.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csa_accumulator.sv
// Packet accumulator that sums signed beats in carry-save form and resolves
// the final sum with one carry-propagate add; optional approximate low carries.
module csa_accumulator #(
    parameter int IN_SIZE     = 8,
    parameter int ACC_SIZE    = 12,
    parameter int MAX_TERMS   = 8,
    parameter int APPROX_BITS = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [IN_SIZE-1:0]  in_data,
    input  logic                in_last,
    input  logic                approx_en,
    output logic                in_ready,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ACC_SIZE-1:0] out_data,
    output logic [3:0]          out_count,
    output logic                out_trunc
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ACCUM   = 2'd1;
    localparam logic [1:0] RESOLVE = 2'd2;
    localparam logic [1:0] OUTPUT  = 2'd3;

    logic [1:0]          state;
    logic [ACC_SIZE-1:0] sum_reg;
    logic [ACC_SIZE-1:0] carry_reg;
    logic [3:0]          count;
    logic                trunc_reg;

    logic                accept;
    logic [ACC_SIZE-1:0] x_ext;
    logic [ACC_SIZE-1:0] maj;
    logic [ACC_SIZE-1:0] keep_mask;
    logic [4:0]          count_inc;
    logic                closing;

    assign in_ready  = (state == IDLE) || (state == ACCUM);
    assign out_valid = (state == OUTPUT);
    assign accept    = in_valid && in_ready;

    assign x_ext     = {{(ACC_SIZE-IN_SIZE){in_data[IN_SIZE-1]}}, in_data};
    assign maj       = (sum_reg & carry_reg) | (sum_reg & x_ext) | (carry_reg & x_ext);
    // Approximation drops the carries generated in the lowest APPROX_BITS columns.
    assign keep_mask = approx_en ? ({ACC_SIZE{1'b1}} << APPROX_BITS) : {ACC_SIZE{1'b1}};
    assign count_inc = {1'b0, count} + 5'd1;
    assign closing   = in_last || (count_inc == 5'(MAX_TERMS));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            sum_reg   <= '0;
            carry_reg <= '0;
            count     <= '0;
            trunc_reg <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
            out_trunc <= 1'b0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (accept) begin
                        sum_reg   <= sum_reg ^ carry_reg ^ x_ext;
                        carry_reg <= (maj & keep_mask) << 1;
                        count     <= count_inc[3:0];
                        trunc_reg <= !in_last;
                        state     <= closing ? RESOLVE : ACCUM;
                    end
                end
                RESOLVE: begin
                    out_data  <= sum_reg + carry_reg;
                    out_count <= count;
                    out_trunc <= trunc_reg;
                    state     <= OUTPUT;
                end
                OUTPUT: begin
                    // Clearing here keeps the carry-save pair at zero throughout IDLE.
                    if (out_ready) begin
                        state     <= IDLE;
                        sum_reg   <= '0;
                        carry_reg <= '0;
                        count     <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_csa_accumulator.sv
// Scoreboard bench for csa_accumulator: directed packets plus random traffic
// checked against a column-by-column full-adder reference model.
module tb_csa_accumulator;

    localparam int IN   = 8;
    localparam int ACC  = 12;
    localparam int MAXT = 8;
    localparam int APX  = 2;

    typedef struct {
        logic [ACC-1:0] data;
        logic [3:0]     count;
        logic           trunc;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic [IN-1:0]  in_data;
    logic           in_last;
    logic           approx_en;
    logic           in_ready;
    logic           out_valid;
    logic           out_ready;
    logic [ACC-1:0] out_data;
    logic [3:0]     out_count;
    logic           out_trunc;

    exp_t           exp_q[$];
    logic [ACC-1:0] m_s;
    logic [ACC-1:0] m_c;
    int             m_count;
    int             errors = 0;
    int             checks = 0;
    logic           rand_ready = 1'b0;

    csa_accumulator #(
        .IN_SIZE(IN), .ACC_SIZE(ACC), .MAX_TERMS(MAXT), .APPROX_BITS(APX)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .approx_en(approx_en), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_count(out_count), .out_trunc(out_trunc)
    );

    always #5 clk = ~clk;

    function automatic void checkOutput(input string name, input logic [31:0] act,
                                        input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
        end
    endfunction

    // Reference: ripple each column as an independent full adder, then drop
    // carries out of the approximated columns.
    function automatic void modelBeat(input logic [IN-1:0] d, input logic l, input logic a);
        logic [ACC-1:0] x;
        logic [ACC-1:0] ns;
        logic [ACC-1:0] nc;
        int tot;
        exp_t e;
        x  = {{(ACC-IN){d[IN-1]}}, d};
        ns = '0;
        nc = '0;
        for (int i = 0; i < ACC; i++) begin
            tot = int'(m_s[i]) + int'(m_c[i]) + int'(x[i]);
            ns[i] = (tot % 2) == 1;
            if (i + 1 < ACC && tot >= 2 && !(a && i < APX)) nc[i+1] = 1'b1;
        end
        m_count++;
        if (l || m_count == MAXT) begin
            e.data  = ns + nc;
            e.count = 4'(m_count);
            e.trunc = !l;
            exp_q.push_back(e);
            m_s = '0;
            m_c = '0;
            m_count = 0;
        end else begin
            m_s = ns;
            m_c = nc;
        end
    endfunction

    // Called at posedge+1; returns at posedge+1 after the beat is taken.
    task automatic applyStimulus(input logic [IN-1:0] d, input logic l, input logic a);
        int waited = 0;
        in_valid  = 1'b1;
        in_data   = d;
        in_last   = l;
        approx_en = a;
        @(negedge clk);
        while (!in_ready) begin
            waited++;
            if (waited > 200) begin
                checkOutput("in_ready_timeout", 32'd0, 32'd1);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        @(posedge clk);
        modelBeat(d, l, a);
        #1 in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // After the closing beat with out_ready=1: RESOLVE, OUTPUT, back to IDLE.
    task automatic closeChecks(input logic [ACC-1:0] d, input logic [3:0] n, input logic t);
        @(negedge clk);
        checkOutput("resolve_out_valid", 32'(out_valid), 32'd0);
        checkOutput("resolve_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        checkOutput("out_valid_latency", 32'(out_valid), 32'd1);
        checkOutput("out_data", 32'(out_data), 32'(d));
        checkOutput("out_count", 32'(out_count), 32'(n));
        checkOutput("out_trunc", 32'(out_trunc), 32'(t));
        @(negedge clk);
        checkOutput("in_ready_after_consume", 32'(in_ready), 32'd1);
        checkOutput("out_valid_after_consume", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic checkResetOutputs();
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_data", 32'(out_data), 32'd0);
        checkOutput("rst_out_count", 32'(out_count), 32'd0);
        checkOutput("rst_out_trunc", 32'(out_trunc), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    endtask

    // Monitor: every result handshake pops and compares one scoreboard entry.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_result", 32'(out_data), 32'hDEAD);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput("sb_data", 32'(out_data), 32'(e.data));
                checkOutput("sb_count", 32'(out_count), 32'(e.count));
                checkOutput("sb_trunc", 32'(out_trunc), 32'(e.trunc));
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int waited;
        int len;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        approx_en = 1'b0; out_ready = 1'b1;
        m_s = '0; m_c = '0; m_count = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkResetOutputs();
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1);

        applyStimulus(8'd10, 1'b0, 1'b0);
        applyStimulus(8'd20, 1'b0, 1'b0);
        applyStimulus(8'd30, 1'b1, 1'b0);
        closeChecks(12'd60, 4'd3, 1'b0);

        applyStimulus(8'h80, 1'b0, 1'b0);
        applyStimulus(8'h7F, 1'b0, 1'b0);
        applyStimulus(8'hFF, 1'b1, 1'b0);
        closeChecks(12'hFFE, 4'd3, 1'b0);

        for (int i = 0; i < 8; i++) applyStimulus(8'd127, 1'b0, 1'b0);
        closeChecks(12'd1016, 4'd8, 1'b1);

        applyStimulus(8'd3, 1'b0, 1'b1);
        applyStimulus(8'd1, 1'b1, 1'b1);
        closeChecks(12'd2, 4'd2, 1'b0);
        applyStimulus(8'd3, 1'b0, 1'b0);
        applyStimulus(8'd1, 1'b1, 1'b0);
        closeChecks(12'd4, 4'd2, 1'b0);

        // Backpressure: result held, stray beats offered meanwhile are ignored.
        out_ready = 1'b0;
        applyStimulus(8'd1, 1'b0, 1'b0);
        applyStimulus(8'd2, 1'b0, 1'b0);
        applyStimulus(8'd3, 1'b1, 1'b0);
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'd99; in_last = 1'b1;
        repeat (5) begin
            @(negedge clk);
            checkOutput("hold_out_valid", 32'(out_valid), 32'd1);
            checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
            checkOutput("hold_out_data", 32'(out_data), 32'd6);
            checkOutput("hold_out_count", 32'(out_count), 32'd3);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("release_out_valid", 32'(out_valid), 32'd1);
        @(negedge clk);
        checkOutput("release_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        applyStimulus(8'd7, 1'b1, 1'b0);
        closeChecks(12'd7, 4'd1, 1'b0);

        // Reset mid-packet discards the partial sum.
        applyStimulus(8'd50, 1'b0, 1'b0);
        applyStimulus(8'd50, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        m_s = '0; m_c = '0; m_count = 0;
        @(negedge clk);
        checkResetOutputs();
        @(posedge clk);
        #1;
        applyStimulus(8'd5, 1'b1, 1'b0);
        closeChecks(12'd5, 4'd1, 1'b0);

        // Reset while a result is waiting in OUTPUT.
        out_ready = 1'b0;
        applyStimulus(8'd9, 1'b1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("pre_rst_out_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        exp_q.delete();
        @(negedge clk);
        checkResetOutputs();
        @(posedge clk);
        #1 out_ready = 1'b1;

        rand_ready = 1'b1;
        for (int p = 0; p < 40; p++) begin
            len = $urandom_range(1, 11);
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
                applyStimulus(8'($urandom_range(0, 255)), k == len - 1,
                              $urandom_range(0, 1) == 1);
            end
        end
        rand_ready = 1'b0;
        idle(1);
        out_ready = 1'b1;
        waited = 0;
        while (exp_q.size() != 0 && waited < 300) begin
            @(posedge clk);
            waited++;
        end
        checkOutput("drain_queue_empty", 32'(exp_q.size()), 32'd0);
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
